// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream traffic generator.
package axis_traffic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Widest tkeep the helpers support (512-bit tdata).
  localparam int KEEP_MAX = 64;

  // Mask with the low 'rem' byte lanes set; a remainder of 0 (or a full bus)
  // means the beat is completely filled.
  function automatic logic [KEEP_MAX-1:0] keep_from_rem(input logic [31:0] rem);
    logic [KEEP_MAX-1:0] mask;
    if (rem == 32'd0 || rem >= 32'(KEEP_MAX)) begin
      mask = '1;
    end else begin
      mask = (KEEP_MAX'(1) << rem) - KEEP_MAX'(1);
    end
    return mask;
  endfunction

  // Number of set bits, used to count delivered bytes per handshake.
  function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] v);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      cnt = cnt + 8'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_traffic_gen_payload.sv
// Payload former: byte j of packet p carries (seed + p + j) mod 256.
// Purely combinational; the top holds the inputs steady while a beat stalls.
module axis_traffic_gen_payload
  import axis_traffic_gen_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic [7:0]            seed,
  input  logic [7:0]            pkt_idx,
  input  logic [LEN_WIDTH-1:0]  byte_off,
  input  logic [DWIDTH/8-1:0]   keep,
  output logic [DWIDTH-1:0]     tdata
);

  logic [7:0] base;

  // Only the low byte of the offset matters because the pattern wraps mod 256.
  assign base = seed + pkt_idx + 8'(byte_off);

  genvar gi;
  generate
    for (gi = 0; gi < DWIDTH/8; gi++) begin : g_lane
      // Lanes outside tkeep are driven to zero.
      assign tdata[gi*8 +: 8] = keep[gi] ? (base + 8'(gi)) : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI4-Stream packet source: configurable length, count and inter-packet gap,
// self-describing payload, per-run packet/byte counters.
module axis_traffic_gen
  import axis_traffic_gen_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 8,
  parameter int HAS_KEEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [31:0]           cfg_pkt_num,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [7:0]            cfg_seed,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DWIDTH/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           sent_pkt_cnt,
  output logic [63:0]           sent_byte_cnt
);

  localparam int B = DWIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] B_LEN = LEN_WIDTH'(B);

  state_t                state_reg, state_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;        // effective packet length in bytes
  logic [LEN_WIDTH-1:0]  rem_reg, rem_next;        // bytes left including current beat
  logic [LEN_WIDTH-1:0]  off_reg, off_next;        // byte offset of current beat
  logic [31:0]           num_reg, num_next;
  logic [GAP_WIDTH-1:0]  gap_reg, gap_next;
  logic [GAP_WIDTH-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [7:0]            seed_reg, seed_next;
  logic [7:0]            pkt_idx_reg, pkt_idx_next;
  logic                  stop_pend_reg, stop_pend_next;
  logic                  done_reg, done_next;
  logic [63:0]           pkt_cnt_reg, pkt_cnt_next;
  logic [63:0]           byte_cnt_reg, byte_cnt_next;

  logic                  tvalid;
  logic                  last_beat;
  logic                  hs;
  logic                  stop_any;
  logic                  run_complete;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic [B-1:0]          keep_beat;
  logic [B-1:0]          keep_out;

  assign tvalid    = (state_reg == ST_SEND);
  assign last_beat = (rem_reg <= B_LEN);
  assign hs        = tvalid & m_axis_tready;
  assign stop_any  = stop_pend_reg | stop;
  assign len_eff   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  // Packet count limit reached on the handshake that completes this packet.
  assign run_complete = (num_reg != 32'd0) && ((pkt_cnt_reg + 64'd1) == {32'd0, num_reg});

  // Partial last beat only when tkeep is in use; otherwise every beat is full.
  always_comb begin
    keep_beat = '1;
    if (HAS_KEEP != 0 && last_beat) begin
      keep_beat = B'(keep_from_rem(32'(rem_reg)));
    end
  end

  assign keep_out = tvalid ? keep_beat : '0;

  axis_traffic_gen_payload #(
    .DWIDTH    (DWIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_payload (
    .seed     (seed_reg),
    .pkt_idx  (pkt_idx_reg),
    .byte_off (off_reg),
    .keep     (keep_out),
    .tdata    (m_axis_tdata)
  );

  assign m_axis_tvalid = tvalid;
  assign m_axis_tkeep  = keep_out;
  assign m_axis_tlast  = tvalid & last_beat;
  assign busy          = (state_reg == ST_SEND) || (state_reg == ST_GAP);
  assign done          = done_reg;
  assign sent_pkt_cnt  = pkt_cnt_reg;
  assign sent_byte_cnt = byte_cnt_reg;

  // Next-state and datapath update for the run FSM.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    rem_next       = rem_reg;
    off_next       = off_reg;
    num_next       = num_reg;
    gap_next       = gap_reg;
    gap_cnt_next   = gap_cnt_reg;
    seed_next      = seed_reg;
    pkt_idx_next   = pkt_idx_reg;
    stop_pend_next = stop_pend_reg;
    done_next      = done_reg;
    pkt_cnt_next   = pkt_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // stop is meaningless here; a simultaneous start simply wins.
        if (start) begin
          state_next     = ST_SEND;
          len_next       = len_eff;
          rem_next       = len_eff;
          off_next       = '0;
          num_next       = cfg_pkt_num;
          gap_next       = cfg_gap;
          seed_next      = cfg_seed;
          pkt_idx_next   = '0;
          stop_pend_next = 1'b0;
          done_next      = 1'b0;
          pkt_cnt_next   = '0;
          byte_cnt_next  = '0;
        end
      end

      ST_SEND: begin
        if (stop) begin
          stop_pend_next = 1'b1;
        end
        if (hs) begin
          byte_cnt_next = byte_cnt_reg + 64'(popcount(KEEP_MAX'(keep_beat)));
          if (last_beat) begin
            pkt_cnt_next = pkt_cnt_reg + 64'd1;
            pkt_idx_next = pkt_idx_reg + 8'd1;
            rem_next     = len_reg;
            off_next     = '0;
            if (run_complete || stop_any) begin
              state_next     = ST_DONE;
              done_next      = 1'b1;
              stop_pend_next = 1'b0;
            end else if (gap_reg != '0) begin
              state_next   = ST_GAP;
              gap_cnt_next = gap_reg;
            end
          end else begin
            rem_next = rem_reg - B_LEN;
            off_next = off_reg + B_LEN;
          end
        end
      end

      ST_GAP: begin
        // A stop seen during the gap ends the run without another packet.
        if (stop_any) begin
          state_next     = ST_DONE;
          done_next      = 1'b1;
          stop_pend_next = 1'b0;
        end else if (gap_cnt_reg <= GAP_WIDTH'(1)) begin
          state_next = ST_SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_WIDTH'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      rem_reg       <= '0;
      off_reg       <= '0;
      num_reg       <= '0;
      gap_reg       <= '0;
      gap_cnt_reg   <= '0;
      seed_reg      <= '0;
      pkt_idx_reg   <= '0;
      stop_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
      pkt_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      rem_reg       <= rem_next;
      off_reg       <= off_next;
      num_reg       <= num_next;
      gap_reg       <= gap_next;
      gap_cnt_reg   <= gap_cnt_next;
      seed_reg      <= seed_next;
      pkt_idx_reg   <= pkt_idx_next;
      stop_pend_reg <= stop_pend_next;
      done_reg      <= done_next;
      pkt_cnt_reg   <= pkt_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen (DWIDTH=32) with a byte-level
// packet model and a per-cycle stream monitor.
module tb_axis_traffic_gen;

  localparam int DW = 32;
  localparam int B  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [15:0]   cfg_pkt_len;
  logic [31:0]   cfg_pkt_num;
  logic [7:0]    cfg_gap;
  logic [7:0]    cfg_seed;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [B-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [63:0]   sent_pkt_cnt;
  logic [63:0]   sent_byte_cnt;

  axis_traffic_gen #(
    .DWIDTH(DW), .LEN_WIDTH(16), .GAP_WIDTH(8), .HAS_KEEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num),
    .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
    .sent_pkt_cnt(sent_pkt_cnt), .sent_byte_cnt(sent_byte_cnt)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    hs_total = 0;
  int    last_hs_cyc = 0;
  int    gap_expect = 0;
  int    idle_cnt = 0;
  bit    in_gap = 0;
  bit    rnd_ready = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;
  beat_t exp_q[$];
  beat_t got_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference packets built byte by byte from the payload rule.
  task automatic push_pkts(input int len, input int npk, input int seed);
    int eff;
    beat_t b;
    eff = (len == 0) ? 1 : len;
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k * B < eff; k++) begin
        b = '0;
        for (int i = 0; i < B; i++) begin
          int j;
          j = k * B + i;
          if (j < eff) begin
            b.data[8*i +: 8] = 8'((seed + p + j) % 256);
            b.keep[i] = 1'b1;
          end
        end
        b.last = ((k + 1) * B >= eff);
        exp_q.push_back(b);
      end
    end
  endtask

  // Ready pattern: constant 1 or a fair coin each cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: scoreboard, hold-stability and inter-packet idle length.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_stable", {27'd0, m_axis_tvalid, 36'(cur)}, {27'd0, 1'b1, 36'(prev_beat)});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_total++;
        got_q.push_back(cur);
        if (m_axis_tlast) last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: actual=%h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
        $display("beat data=%h keep=%b last=%0d pkts=%0d", m_axis_tdata, m_axis_tkeep,
                 m_axis_tlast, sent_pkt_cnt);
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        in_gap = 1;
        idle_cnt = 0;
      end else if (in_gap) begin
        if (m_axis_tvalid) begin
          check("gap_idle_cycles", 64'(idle_cnt), 64'(gap_expect));
          in_gap = 0;
        end else begin
          idle_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat = cur;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic run(input int len, input int num, input int gap, input int seed,
                     input bit rnd, input int npk_model);
    cfg_pkt_len = 16'(len);
    cfg_pkt_num = 32'(num);
    cfg_gap     = 8'(gap);
    cfg_seed    = 8'(seed);
    rnd_ready   = rnd;
    gap_expect  = gap;
    in_gap      = 0;
    exp_q.delete();
    got_q.delete();
    push_pkts(len, npk_model, seed);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_state", {59'd0, m_axis_tvalid, busy, done, |sent_pkt_cnt, |sent_byte_cnt},
          {59'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic finish_run(input int pkts, input int bytes, input int max_cyc);
    bit ok;
    int done_cyc;
    ok = 0;
    done_cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        done_cyc = cyc;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: actual=0 required=1 within %0d cycles", max_cyc);
    end else begin
      check("done_after_last", 64'(done_cyc - last_hs_cyc), 64'd1);
    end
    check("sent_pkt_cnt", sent_pkt_cnt, 64'(pkts));
    check("sent_byte_cnt", sent_byte_cnt, 64'(bytes));
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    $display("run end pkts=%0d bytes=%0d", sent_pkt_cnt, sent_byte_cnt);
  endtask

  initial begin
    int base;
    bit ok;
    start = 0;
    stop = 0;
    cfg_pkt_len = '0;
    cfg_pkt_num = '0;
    cfg_gap = '0;
    cfg_seed = '0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {m_axis_tvalid, busy, done, m_axis_tlast, m_axis_tkeep,
          m_axis_tdata[23:0], sent_pkt_cnt[15:0], sent_byte_cnt[15:0]}, 64'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("idle_no_valid", {62'd0, m_axis_tvalid, busy}, 64'd0);

    // Directed: len 10, two packets, no gap.
    run(10, 2, 0, 0, 0, 2);
    check("model_pkt0_b2", 64'(exp_q[2]), 64'({32'h00000908, 4'b0011, 1'b1}));
    finish_run(2, 20, 200);
    check("pkt0_beat0", 64'(got_q[0].data), 64'h03020100);
    check("pkt0_beat1", 64'(got_q[1].data), 64'h07060504);
    check("pkt0_beat2", 64'(got_q[2]), 64'({32'h00000908, 4'b0011, 1'b1}));
    check("pkt1_beat0", 64'(got_q[3].data), 64'h04030201);

    // Same config with a random ready pattern.
    run(10, 2, 0, 0, 1, 2);
    finish_run(2, 20, 400);

    // Single-beat packets with a 3-cycle gap.
    run(4, 3, 3, 8'h20, 0, 3);
    finish_run(3, 12, 200);
    check("gap_pkt1_data", 64'(got_q[1]), 64'({32'h24232221, 4'hF, 1'b1}));

    // Randomized runs.
    for (int r = 0; r < 5; r++) begin
      int len, num, gap, seed;
      len  = $urandom_range(1, 40);
      num  = $urandom_range(1, 4);
      gap  = $urandom_range(0, 3);
      seed = $urandom_range(0, 255);
      run(len, num, gap, seed, 1, num);
      finish_run(num, num * len, 2000);
    end

    // Unbounded run ended by stop during packet 2.
    run(64, 0, 0, 8'h5A, 0, 3);
    base = hs_total;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (hs_total - base >= 37) begin
        ok = 1;
        break;
      end
    end
    check("stop_reached_beat", {63'd0, ok}, 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("busy_after_stop", {63'd0, busy}, 64'd1);
    finish_run(3, 192, 500);

    // Restart from DONE, one single-byte packet.
    run(1, 1, 0, 8'hFF, 0, 1);
    finish_run(1, 1, 100);
    check("len1_beat", 64'(got_q[0]), 64'({32'h000000FF, 4'b0001, 1'b1}));

    // Asynchronous reset in the middle of a packet.
    run(64, 0, 0, 8'h11, 0, 2);
    base = hs_total;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs_total - base >= 3) begin
        ok = 1;
        break;
      end
    end
    check("reset_reached_beat", {63'd0, ok}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {m_axis_tvalid, busy, done, m_axis_tlast, 12'd0,
          sent_pkt_cnt[23:0], sent_byte_cnt[23:0]}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {61'd0, m_axis_tvalid, busy, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
